// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone RAM slave: controller state encoding,
// a constant-time ceil(log2) helper and the byte width.
package wb_pkg;

  localparam int WB_BYTE = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } wb_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/wb_ram_array.sv
// Synchronous word array with per-byte write enables and a registered read
// port; the read register clears on reset and otherwise holds between reads.
module wb_ram_array
  import wb_pkg::*;
#(
  parameter int data_width   = 32,
  parameter int strobe_width = data_width / WB_BYTE,
  parameter int depth_log2   = 10
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [depth_log2-1:0]   addr,
  input  logic [strobe_width-1:0] we,
  input  logic                    re,
  input  logic [data_width-1:0]   wdata,
  output logic [data_width-1:0]   rdata
);

  logic [data_width-1:0] mem [1 << depth_log2];

  always_ff @(posedge clock) begin
    for (int i = 0; i < strobe_width; i++) begin
      if (we[i]) mem[addr][i*WB_BYTE +: WB_BYTE] <= wdata[i*WB_BYTE +: WB_BYTE];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/wb_ram.sv
// Wishbone classic slave memory with configurable wait states.
// Define WB_RAM_ERR_EN to add the wb_err port and out-of-range error responses.
module wb_ram
  import wb_pkg::*;
#(
  parameter int                    addr_width   = 32,
  parameter int                    data_width   = 32,
  parameter int                    strobe_width = data_width / WB_BYTE,
  parameter int                    depth_log2   = 10,
  parameter logic [addr_width-1:0] base_addr    = '0,
  parameter int                    wait_states  = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [addr_width-1:0]   wb_adr,
  input  logic [data_width-1:0]   wb_datwr,
  output logic [data_width-1:0]   wb_datrd,
  input  logic                    wb_we,
  input  logic                    wb_stb,
  input  logic                    wb_cyc,
  input  logic [strobe_width-1:0] wb_sel,
`ifdef WB_RAM_ERR_EN
  output logic                    wb_err,
`endif
  output logic                    wb_ack
);

  localparam int LANE_SHIFT = clog2(strobe_width);
  localparam int CNT_W      = 4;

  wb_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic commit;

  logic [addr_width-1:0]   adr_p0;
  logic                    we_p0;
  logic [strobe_width-1:0] sel_p0;
  logic [data_width-1:0]   dat_p0;

  logic [addr_width-1:0]   c_adr;
  logic                    c_we;
  logic [strobe_width-1:0] c_sel;
  logic [data_width-1:0]   c_dat;
  logic [depth_log2-1:0]   c_idx;
  logic                    c_ok;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (wb_cyc && wb_stb) begin
          cnt_nxt = CNT_W'(wait_states);
          if (wait_states == 0) begin
            state_nxt = ACK;
            commit    = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (!wb_cyc) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state_nxt = ACK;
            commit    = 1'b1;
          end
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With zero wait states the commit happens on the sampling edge, so the
  // live bus feeds the array; otherwise the latched request does.
  always_comb begin
    if (state == IDLE) begin
      c_adr = wb_adr;
      c_we  = wb_we;
      c_sel = wb_sel;
      c_dat = wb_datwr;
    end else begin
      c_adr = adr_p0;
      c_we  = we_p0;
      c_sel = sel_p0;
      c_dat = dat_p0;
    end
  end

  assign c_idx = depth_log2'((c_adr - base_addr) >> LANE_SHIFT);

`ifdef WB_RAM_ERR_EN
  localparam logic [addr_width:0] MEM_BYTES = (addr_width + 1)'(strobe_width) << depth_log2;
  logic [addr_width:0] c_diff;
  logic                err_q;

  // An address below base_addr borrows into the top bit and so fails the bound too.
  assign c_diff = {1'b0, c_adr} - {1'b0, base_addr};
  assign c_ok   = c_diff < MEM_BYTES;

  always_ff @(posedge clock) begin
    if (reset) err_q <= 1'b0;
    else if (commit) err_q <= !c_ok;
  end

  assign wb_ack = (state == ACK) && !err_q;
  assign wb_err = (state == ACK) && err_q;
`else
  assign c_ok   = 1'b1;
  assign wb_ack = (state == ACK);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Request capture stage
  always_ff @(posedge clock) begin
    if (state == IDLE && wb_cyc && wb_stb) begin
      adr_p0 <= wb_adr;
      we_p0  <= wb_we;
      sel_p0 <= wb_sel;
      dat_p0 <= wb_datwr;
    end
  end

  wb_ram_array #(
    .data_width  (data_width),
    .strobe_width(strobe_width),
    .depth_log2  (depth_log2)
  ) u_array (
    .clock(clock),
    .reset(reset),
    .addr (c_idx),
    .we   ((commit && c_we && c_ok) ? c_sel : '0),
    .re   (commit && !c_we && c_ok),
    .wdata(c_dat),
    .rdata(wb_datrd)
  );

endmodule

// File: tb/tb_wb_ram.sv
// Bench for wb_ram: three instances (1/0/3 wait states, one with base 0x100 and
// 16 words) checked every cycle against a transaction-level memory model.
module tb_wb_ram;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc_cnt = 0;
  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  logic        reset [3];
  logic [31:0] adr   [3];
  logic [31:0] datwr [3];
  logic [31:0] datrd [3];
  logic        we    [3];
  logic        stb   [3];
  logic        cyc   [3];
  logic [3:0]  sel   [3];
  logic        ack   [3];
  logic        err   [3];

  wb_ram #(.addr_width(32), .data_width(32), .strobe_width(4), .depth_log2(10),
           .base_addr(32'h0), .wait_states(1)) u0 (
    .clock(clock), .reset(reset[0]), .wb_adr(adr[0]), .wb_datwr(datwr[0]),
    .wb_datrd(datrd[0]), .wb_we(we[0]), .wb_stb(stb[0]), .wb_cyc(cyc[0]),
    .wb_sel(sel[0]),
`ifdef WB_RAM_ERR_EN
    .wb_err(err[0]),
`endif
    .wb_ack(ack[0]));

  wb_ram #(.addr_width(32), .data_width(32), .strobe_width(4), .depth_log2(10),
           .base_addr(32'h0), .wait_states(0)) u1 (
    .clock(clock), .reset(reset[1]), .wb_adr(adr[1]), .wb_datwr(datwr[1]),
    .wb_datrd(datrd[1]), .wb_we(we[1]), .wb_stb(stb[1]), .wb_cyc(cyc[1]),
    .wb_sel(sel[1]),
`ifdef WB_RAM_ERR_EN
    .wb_err(err[1]),
`endif
    .wb_ack(ack[1]));

  wb_ram #(.addr_width(32), .data_width(32), .strobe_width(4), .depth_log2(4),
           .base_addr(32'h100), .wait_states(3)) u2 (
    .clock(clock), .reset(reset[2]), .wb_adr(adr[2]), .wb_datwr(datwr[2]),
    .wb_datrd(datrd[2]), .wb_we(we[2]), .wb_stb(stb[2]), .wb_cyc(cyc[2]),
    .wb_sel(sel[2]),
`ifdef WB_RAM_ERR_EN
    .wb_err(err[2]),
`endif
    .wb_ack(ack[2]));

`ifndef WB_RAM_ERR_EN
  assign err[0] = 1'b0;
  assign err[1] = 1'b0;
  assign err[2] = 1'b0;
`endif

  function automatic int ws_of(input int k);
    case (k)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic int dl_of(input int k);
    return (k == 2) ? 4 : 10;
  endfunction

  function automatic logic [31:0] base_of(input int k);
    return (k == 2) ? 32'h100 : 32'h0;
  endfunction

  function automatic bit in_range(input int k, input logic [31:0] a);
`ifdef WB_RAM_ERR_EN
    return (a >= base_of(k)) && ((a - base_of(k)) < (32'd4 << dl_of(k)));
`else
    return (k >= 0) && (a === a);
`endif
  endfunction

  function automatic int idx_of(input int k, input logic [31:0] a);
    logic [31:0] off;
    off = (a - base_of(k)) >> 2;
    return int'(off & ((32'd1 << dl_of(k)) - 32'd1));
  endfunction

  // Transaction-level model, written only by the stimulus process
  logic [31:0] mdl [3][1024];
  logic [31:0] exp_rd [3];
  bit          pend [3];
  int          ack_at [3];
  int          last_ack [3];
  logic        p_we [3];
  logic [3:0]  p_sel [3];
  logic [31:0] p_adr [3];
  logic [31:0] p_dat [3];
  bit          run_chk = 1'b0;
  int          lit_at = -1;
  int          lit_k = 0;
  logic [31:0] lit_val = '0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s u%0d cycle %0d: got %h, want %h", nm, k, cyc_cnt, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (run_chk) begin
      for (int k = 0; k < 3; k++) begin
        logic        e_ack, e_err;
        logic [31:0] e_rd;
        e_ack = 1'b0;
        e_err = 1'b0;
        e_rd  = exp_rd[k];
        if (pend[k] && cyc_cnt == ack_at[k]) begin
          if (in_range(k, p_adr[k])) begin
            e_ack = 1'b1;
            if (!p_we[k]) e_rd = mdl[k][idx_of(k, p_adr[k])];
          end else begin
            e_err = 1'b1;
          end
        end
        chk("ack", k, {31'b0, ack[k]}, {31'b0, e_ack});
        chk("err", k, {31'b0, err[k]}, {31'b0, e_err});
        chk("datrd", k, datrd[k], e_rd);
      end
      if (cyc_cnt == lit_at) chk("literal", lit_k, datrd[lit_k], lit_val);
    end
  end

  task automatic tick();
    @(negedge clock);
    #2;
  endtask

  task automatic issue(input int k, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    int smp;
    adr[k] = a; we[k] = w; sel[k] = s; datwr[k] = d;
    cyc[k] = 1'b1; stb[k] = 1'b1;
    smp = cyc_cnt + 1;
    if (last_ack[k] + 2 > smp) smp = last_ack[k] + 2;
    ack_at[k] = smp + ws_of(k);
    p_we[k] = w; p_sel[k] = s; p_adr[k] = a; p_dat[k] = d;
    pend[k] = 1'b1;
  endtask

  task automatic complete(input int k, input bit keep);
    int ix;
    for (int i = 0; i < 40 && cyc_cnt < ack_at[k]; i++) tick();
    ix = idx_of(k, p_adr[k]);
    if (in_range(k, p_adr[k])) begin
      if (p_we[k]) begin
        for (int i = 0; i < 4; i++)
          if (p_sel[k][i]) mdl[k][ix][8*i +: 8] = p_dat[k][8*i +: 8];
      end else begin
        exp_rd[k] = mdl[k][ix];
      end
    end
    last_ack[k] = cyc_cnt;
    pend[k] = 1'b0;
    if (!keep) begin
      cyc[k] = 1'b0;
      stb[k] = 1'b0;
    end
  endtask

  task automatic xfer(input int k, input logic w, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] d);
    issue(k, w, a, s, d);
    complete(k, 1'b0);
    tick();
  endtask

  task automatic read_lit(input int k, input logic [31:0] a, input logic [31:0] want);
    issue(k, 1'b0, a, 4'h0, 32'h0);
    lit_k = k; lit_val = want; lit_at = ack_at[k];
    complete(k, 1'b0);
    tick();
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      reset[k] = 1'b1; cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
      sel[k] = 4'h0; adr[k] = '0; datwr[k] = '0;
      pend[k] = 1'b0; last_ack[k] = -10; exp_rd[k] = '0; ack_at[k] = -1;
    end
    repeat (3) tick();
    for (int k = 0; k < 3; k++) reset[k] = 1'b0;
    run_chk = 1'b1;
    repeat (2) tick();

    // Full-word write and read-back, then byte lanes and an empty select
    xfer(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    read_lit(0, 32'h10, 32'hDEADBEEF);
    xfer(0, 1'b1, 32'h10, 4'b0101, 32'h11223344);
    read_lit(0, 32'h10, 32'hDE22BE44);
    xfer(0, 1'b1, 32'h10, 4'h0, 32'hFFFFFFFF);
    read_lit(0, 32'h10, 32'hDE22BE44);
    xfer(0, 1'b1, 32'h17, 4'b1010, 32'hA1B2C3D4);
    xfer(0, 1'b1, 32'h14, 4'b0101, 32'h00550066);
    read_lit(0, 32'h14, 32'hA155C366);
    read_lit(0, 32'h10, 32'hDE22BE44);

    // Zero wait states: back-to-back writes then reads with stb held
    xfer(1, 1'b1, 32'h0, 4'hF, 32'h01010101);
    xfer(1, 1'b1, 32'h4, 4'hF, 32'h02020202);
    xfer(1, 1'b1, 32'h8, 4'hF, 32'h03030303);
    issue(1, 1'b0, 32'h0, 4'h0, 32'h0);
    complete(1, 1'b1);
    issue(1, 1'b0, 32'h4, 4'h0, 32'h0);
    lit_k = 1; lit_val = 32'h02020202; lit_at = ack_at[1];
    complete(1, 1'b1);
    issue(1, 1'b0, 32'h8, 4'h0, 32'h0);
    complete(1, 1'b1);
    issue(1, 1'b1, 32'h4, 4'b1000, 32'hEE000000);
    complete(1, 1'b1);
    issue(1, 1'b0, 32'h4, 4'h0, 32'h0);
    lit_k = 1; lit_val = 32'hEE020202; lit_at = ack_at[1];
    complete(1, 1'b0);
    repeat (2) tick();

    // Three wait states: abort after one cycle leaves the word intact
    xfer(2, 1'b1, 32'h120, 4'hF, 32'h5555AAAA);
    issue(2, 1'b1, 32'h120, 4'hF, 32'h12345678);
    tick();
    cyc[2] = 1'b0; stb[2] = 1'b0; pend[2] = 1'b0;
    repeat (3) tick();
    read_lit(2, 32'h120, 32'h5555AAAA);

    // Reset in the middle of a write's wait states
    issue(2, 1'b1, 32'h120, 4'hF, 32'hFFFF0000);
    repeat (2) tick();
    reset[2] = 1'b1; cyc[2] = 1'b0; stb[2] = 1'b0; pend[2] = 1'b0; exp_rd[2] = '0;
    tick();
    reset[2] = 1'b0;
    repeat (2) tick();
    read_lit(2, 32'h120, 32'h5555AAAA);

    // Range edges: error response with the option, aliasing without it
    xfer(2, 1'b1, 32'h100, 4'hF, 32'hCAFEF00D);
    xfer(2, 1'b1, 32'h13C, 4'hF, 32'h0BADC0DE);
    read_lit(2, 32'h13C, 32'h0BADC0DE);
`ifdef WB_RAM_ERR_EN
    read_lit(2, 32'h140, 32'h0BADC0DE);
    read_lit(2, 32'h0FC, 32'h0BADC0DE);
    xfer(2, 1'b1, 32'h140, 4'hF, 32'h11111111);
    read_lit(2, 32'h100, 32'hCAFEF00D);
`else
    read_lit(2, 32'h140, 32'hCAFEF00D);
    read_lit(2, 32'h0FC, 32'h0BADC0DE);
    xfer(2, 1'b1, 32'h140, 4'hF, 32'h11111111);
    read_lit(2, 32'h100, 32'h11111111);
`endif
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_ram.md
Name: wb_ram

Overview:
- Wishbone classic slave memory.
- Consumes the single-master Wishbone bus produced by the core's Wishbone wrapper, which arbitrates instruction and data traffic.
- Serves instruction fetches, data loads and byte-lane stores from an on-chip word array with a configurable number of wait states.
- Acts as the main program/data memory for simulation and FPGA builds.

Parameters:
- addr_width, 32: width of the wb_adr byte address.
- data_width, 32: word width; must be a multiple of 8.
- strobe_width, data_width/8: number of byte lanes in wb_sel.
- depth_log2, 10: log2 of the number of words in the array.
- base_addr, 0: byte address of word 0.
- wait_states, 1: extra cycles inserted before ack; range 0-15.

Ports:
- clock  input  1  single clock; all logic rises on this edge.
- reset  input  1  synchronous, active-high reset.
- wb_adr  input  addr_width  byte address.
- wb_datwr  input  data_width  write data.
- wb_datrd  output  data_width  read data.
- wb_we  input  1  write enable.
- wb_stb  input  1  strobe.
- wb_cyc  input  1  cycle valid.
- wb_sel  input  strobe_width  byte-lane select.
- wb_ack  output  1  transfer acknowledge.
- wb_err  output  1  error acknowledge; present only with WB_RAM_ERR_EN.

Behaviour:
- Reset: one clock, synchronous, active-high. Reset forces state=IDLE, wb_ack=0, wb_err=0, wb_datrd=0 and the wait counter to 0. Array contents are not reset.
- Word index: idx = (wb_adr - base_addr) >> log2(strobe_width), truncated to depth_log2 bits. Byte-offset bits of wb_adr are ignored (no misalignment handling).
- IDLE:
  - When wb_cyc && wb_stb, latch adr, we, sel and datwr.
  - Load cnt = wait_states.
  - Go to WAIT if wait_states>0, otherwise go to ACK.
- WAIT:
  - Decrement cnt each cycle.
  - When cnt==1 and wb_cyc is still high, go to ACK.
  - If wb_cyc drops in WAIT, abort: return to IDLE with no ack, no write and wb_datrd unchanged.
- Commit on the edge entering ACK:
  - Write: for each lane i with sel[i]=1, mem[idx][8i+7:8i] <= datwr lane i. Lanes with sel=0 are untouched. sel=0 gives no change but is still acked.
  - Read: wb_datrd <= mem[idx]; sel is ignored for reads and the full word is returned.
- ACK:
  - wb_ack=1 for exactly one cycle, then IDLE.
  - A new request is accepted in IDLE on the cycle after ACK, so back-to-back transfers cost wait_states+2 cycles each.
- Latency: ack is asserted wait_states+1 cycles after the cycle in which stb is first sampled in IDLE.
- wb_datrd holds its value from the last read until the next read commit. Writes never alter wb_datrd.
- Requests arriving outside IDLE are ignored; the master holds stb until ack.
- Read of a location written in the previous transfer returns the new data (commit-then-read ordering).

Optional Feature:
- Macro: WB_RAM_ERR_EN
- With the macro:
  - Range check on the latched address: in range iff base_addr <= adr < base_addr + (strobe_width << depth_log2).
  - Out-of-range accesses go through the same wait states, then assert wb_err for one cycle instead of wb_ack.
  - No write occurs and wb_datrd is unchanged.
  - wb_ack and wb_err are never both high.
- Without the macro:
  - The wb_err port is absent.
  - Addresses alias modulo array size.
  - Every access is acked.

Decomposition:
- Shared package/header wb_pkg:
  - state encoding IDLE/WAIT/ACK;
  - function clog2;
  - constant WB_BYTE = 8.
- One sub-module, wb_ram_array: synchronous word array with per-byte write enable and registered read port. It is instantiated once and holds no control logic.

Test Plan:
- Reset, wait_states=1: write adr=0x10, dat=0xDEADBEEF, sel=4'hF -> ack 2 cycles after stb, one cycle wide. Read adr=0x10 -> wb_datrd=0xDEADBEEF during ack.
- Byte lanes: word 0x10=0xDEADBEEF, write sel=4'b0101, dat=0x11223344 -> read returns 0xDE22BE44. Write with sel=0 -> ack, data unchanged.
- wait_states=0, back-to-back reads of 0x0/0x4/0x8 with stb held until each ack -> ack every 2nd cycle, correct data each time.
- Abort: wait_states=3, write 0x20, drop cyc after 1 cycle -> no ack, no write; a later read of 0x20 returns the prior value.
- Reset mid-WAIT during a write -> outputs 0 next cycle, state=IDLE, target word unmodified.
- WB_RAM_ERR_EN, depth_log2=4, base_addr=0x100: read 0x140 -> wb_err one cycle, wb_ack=0, wb_datrd unchanged. Without the macro, 0x140 aliases to 0x100.
